// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider
// Purpose  : Sequential unsigned restoring divider, one quotient bit per clock,
//            with a Start/Busy/Done handshake and divide-by-zero flag.
// Revision : 1.0  initial release
// ============================================================================
module alu_divider #(
    parameter int n = 8
) (
    input  logic         Clock,
    input  logic         nReset,
    input  logic         Start,
    input  logic [n:0]   a,
    input  logic [n:0]   b,
    output logic [n:0]   q,
    output logic [n:0]   r,
    output logic         Busy,
    output logic         Done,
    output logic         DivZero
);

    localparam int               c_cw   = $clog2(n + 1);
    localparam logic [c_cw-1:0]  c_last = c_cw'(n);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [n:0]      r_dvd;
    logic [n:0]      r_dvs;
    logic [n:0]      r_rem;
    logic [c_cw-1:0] r_cnt;

    logic            w_accept;
    logic            w_bzero;
    logic [n+1:0]    w_trial;
    logic [n+2:0]    w_diff;
    logic            w_qbit;
    logic [n:0]      w_rem_nxt;
    logic            w_unused;

    assign w_accept  = Start && (r_state != c_run);
    assign w_bzero   = (b == '0);

    // Trial = {remainder, next dividend bit}; the top bit of the widened
    // difference is the borrow out of the n+2-bit subtraction.
    assign w_trial   = {r_rem, r_dvd[n]};
    assign w_diff    = {1'b0, w_trial} - {2'b00, r_dvs};
    assign w_qbit    = ~w_diff[n+2];
    assign w_rem_nxt = w_qbit ? w_diff[n:0] : w_trial[n:0];

    // Both MSBs are provably zero whenever they would be selected.
    assign w_unused  = w_diff[n+1] ^ w_trial[n+1];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_run: begin
                if (r_cnt == c_last) begin
                    w_next = c_done;
                end
            end
            default: begin
                if (Start) begin
                    w_next = w_bzero ? c_done : c_run;
                end else begin
                    w_next = c_idle;
                end
            end
        endcase
    end

    always_comb begin
        Busy = (r_state == c_run);
        Done = (r_state == c_done);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
            q       <= '0;
            r       <= '0;
            DivZero <= 1'b0;
        end else if (w_accept) begin
            r_dvd   <= a;
            r_dvs   <= b;
            r_rem   <= '0;
            r_cnt   <= '0;
            DivZero <= w_bzero;
            if (w_bzero) begin
                q <= '1;
                r <= a;
            end
        end else if (r_state == c_run) begin
            // Quotient bits fill the dividend register from the LSB side.
            r_rem <= w_rem_nxt;
            r_dvd <= {r_dvd[n-1:0], w_qbit};
            r_cnt <= r_cnt + c_cw'(1);
            if (r_cnt == c_last) begin
                q <= {r_dvd[n-1:0], w_qbit};
                r <= w_rem_nxt;
            end
        end
    end

endmodule
`default_nettype wire
